// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit mult/multu/div/divu unit with HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        count;
    logic                 is_div;
    logic [WIDTH-1:0]     opnd;
    logic [2*WIDTH-1:0]   acc;
    logic                 neg_prod;
    logic                 neg_quo;
    logic                 neg_rem;

    logic                 signed_op;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       rem_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == CW'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // acc holds {upper, multiplier} for multiply and {rem, quo} for divide;
    // opnd is the multiplicand or the divisor respectively.
    always_comb begin
        signed_op = ~op[0];
        a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
        b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
        mul_sum   = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd})
                           : {1'b0, acc[2*WIDTH-1:WIDTH]};
        rem_sh    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_diff  = rem_sh - {1'b0, opnd};
        div_ge    = (rem_sh >= {1'b0, opnd});
        if (is_div) begin
            acc_step = {(div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                        acc[WIDTH-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
        prod_fix = neg_prod ? -acc : acc;
        quo_fix  = neg_quo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            is_div   <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            neg_prod <= 1'b0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div   <= op[1];
                        opnd     <= op[1] ? b_mag : a_mag;
                        acc      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                        count    <= '0;
                        neg_prod <= signed_op & ~op[1] & (a[WIDTH-1] ^ b[WIDTH-1]);
                        // A zero divisor must leave the quotient all ones.
                        neg_quo  <= signed_op & op[1] & (a[WIDTH-1] ^ b[WIDTH-1]) & (|b);
                        neg_rem  <= signed_op & op[1] & a[WIDTH-1];
                    end else begin
                        if (mthi) hi <= wd;
                        if (mtlo) lo <= wd;
                    end
                end
                RUN: begin
                    acc   <= acc_step;
                    count <= count + CW'(1);
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic [W-1:0] wd = '0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    int checks = 0;
    int passed = 0;
    int overlap = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wd(wd), .hi(hi), .lo(lo),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy && done) overlap++;

    // Reference: {hi, lo} from plain arithmetic on the architectural rules.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        int     ix, iy;
        logic [63:0] r;
        sx = $signed(x);
        sy = $signed(y);
        ix = x;
        iy = y;
        case (o)
            2'b00: r = sx * sy;
            2'b01: r = {32'd0, x} * {32'd0, y};
            2'b10: begin
                if (y == 0)                                 r = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == '1)     r = {32'd0, 32'h8000_0000};
                else                                        r = {32'(ix % iy), 32'(ix / iy)};
            end
            default: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else        r = {x % y, x / y};
            end
        endcase
        return r;
    endfunction

    // Drives one operation; reports result and timing, compares nothing.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic with_mtlo,
                          output logic [31:0] rh, output logic [31:0] rl,
                          output int bcnt, output int edges);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1; mtlo = with_mtlo;
        @(posedge clk); #1;
        start = 1'b0; mtlo = 1'b0;
        bcnt = busy ? 1 : 0;
        edges = -1;
        rh = 'x; rl = 'x;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk); #1;
            if (busy) bcnt++;
            if (done) begin
                edges = i;
                rh = hi;
                rl = lo;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (hi !== 0)   $display("FAIL reset_hi got %h want 0", hi);   else passed++;
        checks++; if (lo !== 0)   $display("FAIL reset_lo got %h want 0", lo);   else passed++;
        checks++; if (busy !== 0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (done !== 0) $display("FAIL reset_done got %b want 0", done); else passed++;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_directed;
        logic [31:0] rh, rl;
        int bc, ed;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, rh, rl, bc, ed);
        checks++; if (rh !== 32'hFFFF_FFFE) $display("FAIL multu_max_hi got %h want fffffffe", rh); else passed++;
        checks++; if (rl !== 32'h0000_0001) $display("FAIL multu_max_lo got %h want 00000001", rl); else passed++;
        checks++; if (bc !== W + 1) $display("FAIL multu_busy_cycles got %0d want %0d", bc, W + 1); else passed++;
        checks++; if (ed !== W + 1) $display("FAIL multu_done_edge got %0d want %0d", ed, W + 1); else passed++;
        @(posedge clk); #1;
        checks++; if (done !== 0) $display("FAIL done_single_pulse got %b want 0", done); else passed++;

        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, rh, rl, bc, ed);
        checks++; if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FFEB) $display("FAIL mult_neg got %h%h want ffffffffffffffeb", rh, rl); else passed++;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, rh, rl, bc, ed);
        checks++; if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_b2b got %h%h want fffffffffffffffd", rh, rl); else passed++;
        checks++; if (ed !== W + 1) $display("FAIL div_b2b_latency got %0d want %0d", ed, W + 1); else passed++;

        run_op(2'b11, 32'd100, 32'd0, 1'b0, rh, rl, bc, ed);
        checks++; if ({rh, rl} !== {32'd100, 32'hFFFF_FFFF}) $display("FAIL divu_by_zero got %h%h want 00000064ffffffff", rh, rl); else passed++;
        checks++; if (ed !== W + 1) $display("FAIL divu_zero_latency got %0d want %0d", ed, W + 1); else passed++;
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, rh, rl, bc, ed);
        checks++; if ({rh, rl} !== {32'd0, 32'h8000_0000}) $display("FAIL div_overflow got %h%h want 0000000080000000", rh, rl); else passed++;
        run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0, rh, rl, bc, ed);
        checks++; if ({rh, rl} !== {32'hFFFF_FFF0, 32'hFFFF_FFFF}) $display("FAIL div_neg_by_zero got %h%h want fffffff0ffffffff", rh, rl); else passed++;
    endtask

    task automatic test_moves;
        logic [31:0] rh, rl, lo_before;
        int bc, ed;
        @(negedge clk); mthi = 1'b1; wd = 32'h1234_5678;
        @(posedge clk); #1; mthi = 1'b0;
        checks++; if (hi !== 32'h1234_5678) $display("FAIL mthi got %h want 12345678", hi); else passed++;
        @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wd = 32'hCAFE_F00D;
        @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
        checks++; if ({hi, lo} !== {2{32'hCAFE_F00D}}) $display("FAIL mthi_mtlo_both got %h%h want cafef00dcafef00d", hi, lo); else passed++;

        // start together with mtlo: the move is dropped, the operation runs
        wd = 32'hDEAD_BEEF;
        @(negedge clk);
        op = 2'b01; a = 32'd9; b = 32'd11; start = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1; start = 1'b0; mtlo = 1'b0;
        checks++; if (lo !== 32'hCAFE_F00D) $display("FAIL start_mtlo_dropped got %h want cafef00d", lo); else passed++;
        lo_before = lo;
        repeat (5) @(posedge clk);
        @(negedge clk); mtlo = 1'b1; mthi = 1'b1; wd = 32'h5555_AAAA;
        @(posedge clk); #1; mtlo = 1'b0; mthi = 1'b0;
        checks++; if (lo !== lo_before) $display("FAIL mtlo_while_busy got %h want %h", lo, lo_before); else passed++;
        ed = -1;
        for (int i = 0; i < 60; i++) begin
            if (done) begin ed = i; break; end
            @(posedge clk); #1;
        end
        checks++; if (ed < 0 || {hi, lo} !== 64'd99) $display("FAIL op_after_moves got %h%h want %h", hi, lo, 64'd99); else passed++;
        run_op(2'b01, 32'd3, 32'd3, 1'b0, rh, rl, bc, ed);
    endtask

    task automatic test_reset_mid;
        logic [31:0] rh, rl;
        int bc, ed, dcnt;
        @(negedge clk);
        op = 2'b00; a = 32'h0001_0001; b = 32'hFFFF_0003; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        checks++; if ({hi, lo} !== 64'd0) $display("FAIL mid_reset_hilo got %h%h want 0", hi, lo); else passed++;
        checks++; if (busy !== 0) $display("FAIL mid_reset_busy got %b want 0", busy); else passed++;
        @(negedge clk); reset = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) dcnt++;
        end
        checks++; if (dcnt !== 0) $display("FAIL mid_reset_quiet got %0d active cycles want 0", dcnt); else passed++;
        run_op(2'b01, 32'd6, 32'd7, 1'b0, rh, rl, bc, ed);
        checks++; if ({rh, rl} !== 64'd42) $display("FAIL multu_after_reset got %h%h want 42", rh, rl); else passed++;
    endtask

    task automatic test_start_while_busy;
        logic [63:0] exp, got;
        logic [31:0] hold_hi, hold_lo;
        int dcnt, stable;
        exp = model(2'b00, 32'h0000_1234, 32'hFFFF_5678);
        hold_hi = hi; hold_lo = lo;
        @(negedge clk);
        op = 2'b00; a = 32'h0000_1234; b = 32'hFFFF_5678; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        dcnt = 0; stable = 1; got = 'x;
        for (int i = 1; i < 70; i++) begin
            @(negedge clk);
            if (i < 25) begin
                start = i[0]; op = 2'b11; a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (busy && (hi !== hold_hi || lo !== hold_lo)) stable = 0;
            if (done) begin dcnt++; got = {hi, lo}; end
        end
        start = 1'b0;
        checks++; if (dcnt !== 1) $display("FAIL busy_start_done_count got %0d want 1", dcnt); else passed++;
        checks++; if (got !== exp) $display("FAIL busy_start_result got %h want %h", got, exp); else passed++;
        checks++; if (stable !== 1) $display("FAIL hilo_hold_while_busy got %0d want 1", stable); else passed++;
    endtask

    task automatic test_random;
        logic [31:0] rh, rl, x, y;
        logic [1:0]  o;
        logic [63:0] exp;
        logic [31:0] corner [5];
        int bc, ed;
        corner[0] = 32'h0; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFF; corner[4] = 32'h1;
        for (int n = 0; n < 30; n++) begin
            o = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom >> $urandom_range(0, 28));
            exp = model(o, x, y);
            run_op(o, x, y, 1'b0, rh, rl, bc, ed);
            checks++;
            if ({rh, rl} !== exp || ed !== W + 1)
                $display("FAIL random_op%0d op=%0d a=%h b=%h got %h%h edge %0d want %h edge %0d",
                         n, o, x, y, rh, rl, ed, exp, W + 1);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_moves();
        test_reset_mid();
        test_start_while_busy();
        test_random();
        checks++; if (overlap !== 0) $display("FAIL busy_done_overlap got %0d want 0", overlap); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
